// File: rtl/fir_decim_rescale.sv
// rtl/fir_decim_rescale.sv - integrate-and-dump decimator with round/shift/saturate and output FIFO (optional FIR_DECIM_SAT_CNT_EN)
module fir_decim_rescale #(
  parameter int IN_W       = 30,
  parameter int ACC_W      = IN_W + 8,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  din,
  input  logic                    din_vld,
  input  logic [7:0]              decim_n,
  output logic signed [OUT_W-1:0] dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    ovf,
  input  logic                    ovf_clr
`ifdef FIR_DECIM_SAT_CNT_EN
  ,
  output logic [15:0]             sat_cnt
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Output limits and rounding constant, all at the widened ACC_W+1 width
  localparam logic signed [ACC_W:0] OUT_MAX = {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] OUT_MIN = {{(ACC_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};
  localparam logic signed [ACC_W:0] RND     = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] s_sum;
  logic signed [ACC_W-1:0] din_ext;
  logic signed [ACC_W-1:0] sum_next;
  logic [7:0]              cnt;
  logic [7:0]              r_lat;
  logic [7:0]              r_new;
  logic [7:0]              r_eff;
  logic                    last;
  logic                    s_vld;

  // A new frame uses the live ratio; later samples use the value latched at frame start
  assign din_ext  = {{(ACC_W - IN_W){din[IN_W-1]}}, din};
  assign r_new    = (decim_n == 8'd0) ? 8'd1 : decim_n;
  assign r_eff    = (cnt == 8'd0) ? r_new : r_lat;
  assign sum_next = (cnt == 8'd0) ? din_ext : acc + din_ext;
  assign last     = (cnt == r_eff - 8'd1);

  // Accumulate accepted samples and dump the final sum into the stage register
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      cnt   <= '0;
      r_lat <= 8'd1;
      s_sum <= '0;
      s_vld <= 1'b0;
    end else begin
      s_vld <= din_vld && last;
      if (din_vld) begin
        acc <= sum_next;
        if (cnt == 8'd0) begin
          r_lat <= r_new;
        end
        if (last) begin
          s_sum <= sum_next;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

  logic signed [ACC_W:0]   rnd_sum;
  logic signed [ACC_W:0]   r_shift;
  logic                    sat_hi;
  logic                    sat_lo;
  logic signed [OUT_W-1:0] res;

  // Round half toward +inf, shift, then clip to the output range
  always_comb begin
    rnd_sum = {s_sum[ACC_W-1], s_sum} + RND;
    r_shift = rnd_sum >>> SHIFT;
    sat_hi  = (r_shift > OUT_MAX);
    sat_lo  = (r_shift < OUT_MIN);
    if (sat_hi) begin
      res = OUT_MAX[OUT_W-1:0];
    end else if (sat_lo) begin
      res = OUT_MIN[OUT_W-1:0];
    end else begin
      res = r_shift[OUT_W-1:0];
    end
  end

  logic [OUT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             pop;
  logic             push_ok;

  // A pop in the same cycle frees the slot for a push into a full FIFO
  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign dout_valid = (count != '0);
  assign pop        = dout_valid && dout_ready;
  assign push_ok    = s_vld && (!full || pop);
  assign dout       = dout_valid ? mem[rd_ptr] : '0;

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= res;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (ovf_clr) begin
        ovf <= 1'b0;
      end else if (s_vld && !push_ok) begin
        ovf <= 1'b1;
      end
    end
  end

`ifdef FIR_DECIM_SAT_CNT_EN
  // Count clipped results at FIFO write time, dropped or not; saturating
  always_ff @(posedge clk) begin
    if (rst || ovf_clr) begin
      sat_cnt <= '0;
    end else if (s_vld && (sat_hi || sat_lo) && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fir_decim_rescale.sv
// tb/tb_fir_decim_rescale.sv - scoreboard bench for fir_decim_rescale (SHIFT=4)
module tb_fir_decim_rescale;

  localparam int IN_W  = 30;
  localparam int OUT_W = 16;
  localparam int SHIFT = 4;

  logic                    clk;
  logic                    rst;
  logic signed [IN_W-1:0]  din;
  logic                    din_vld;
  logic [7:0]              decim_n;
  logic signed [OUT_W-1:0] dout;
  logic                    dout_valid;
  logic                    dout_ready;
  logic                    ovf;
  logic                    ovf_clr;
`ifdef FIR_DECIM_SAT_CNT_EN
  logic [15:0]             sat_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int pops        = 0;

  longint exp_q[$];
  longint m_acc;
  int     m_cnt;
  int     m_rlat;
  int     m_sat;

  fir_decim_rescale #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .SHIFT(SHIFT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_vld   (din_vld),
    .decim_n   (decim_n),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
`ifdef FIR_DECIM_SAT_CNT_EN
    ,
    .sat_cnt   (sat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint rescale(input longint s);
    longint r;
    r = (s + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    if (r > 32767) return 32767;
    if (r < -32768) return -32768;
    return r;
  endfunction

  function automatic bit clipped(input longint s);
    longint r;
    r = (s + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    return (r > 32767) || (r < -32768);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    din_vld = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drive one accepted sample and advance the reference frame model
  task automatic send(input longint v);
    din     = IN_W'(v);
    din_vld = 1'b1;
    if (m_cnt == 0) begin
      m_rlat = (decim_n == 8'd0) ? 1 : int'(decim_n);
      m_acc  = v;
    end else begin
      m_acc = m_acc + v;
    end
    if (m_cnt == m_rlat - 1) begin
      exp_q.push_back(rescale(m_acc));
      if (clipped(m_acc)) m_sat++;
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
    tick();
    din_vld = 1'b0;
  endtask

  // Scoreboard: every handshake pops the oldest expected result
  always @(negedge clk) begin
    if (!rst && dout_valid === 1'b1 && dout_ready === 1'b1) begin
      pops++;
      if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
      else chk("dout", dout, exp_q.pop_front());
    end
  end

  initial begin
    rst        = 1'b1;
    din        = '0;
    din_vld    = 1'b0;
    decim_n    = 8'd4;
    dout_ready = 1'b1;
    ovf_clr    = 1'b0;
    m_acc      = 0;
    m_cnt      = 0;
    m_rlat     = 1;
    m_sat      = 0;

    tick();
    tick();
    chk("rst_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ovf", ovf, 0);
`ifdef FIR_DECIM_SAT_CNT_EN
    chk("rst_sat_cnt", sat_cnt, 0);
`endif
    rst = 1'b0;
    tick();

    // R=4, din=10: result 3, latency check around the 4th sample
    for (int i = 0; i < 4; i++) send(10);
    chk("lat_valid_early", dout_valid, 0);
    send(10);
    chk("lat_valid", dout_valid, 1);
    chk("lat_dout", dout, 3);
    for (int i = 0; i < 3; i++) send(10);
    idle(4);

    // R=4, din=-10: result -2 (round half up on negatives)
    for (int i = 0; i < 4; i++) send(-10);
    idle(4);

    // R=16, full scale both signs: clip to +32767 / -32768
    decim_n = 8'd16;
    for (int i = 0; i < 16; i++) send(longint'(1) <<< 20);
    for (int i = 0; i < 16; i++) send(-(longint'(1) <<< 20));
    idle(4);
`ifdef FIR_DECIM_SAT_CNT_EN
    chk("sat_cnt", sat_cnt, m_sat);
`endif
    chk("q_empty_sat", exp_q.size(), 0);

    // R=1, consumer stalled: 4 held, 2 dropped, ovf sticky
    decim_n    = 8'd1;
    dout_ready = 1'b0;
    for (int k = 1; k <= 6; k++) send(16 * k);
    idle(2);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    chk("ovf_set", ovf, 1);
    chk("full_valid", dout_valid, 1);
    chk("full_head", dout, 1);
    pops = 0;
    dout_ready = 1'b1;
    idle(6);
    chk("drain_pops", pops, 4);
    chk("drain_valid", dout_valid, 0);
    chk("ovf_sticky", ovf, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", ovf, 0);

    // decim_n 4 -> 2 mid-frame: current frame still sums 4 samples
    decim_n = 8'd4;
    send(16);
    send(16);
    decim_n = 8'd2;
    send(16);
    send(16);
    send(16);
    send(16);
    idle(4);
    chk("q_empty_decim", exp_q.size(), 0);

    // Reset at cnt=3 discards the partial frame
    decim_n = 8'd4;
    for (int i = 0; i < 3; i++) send(16);
    idle(3);
    chk("partial_no_valid", dout_valid, 0);
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    m_cnt = 0;
    m_sat = 0;
    chk("rst_mid_valid", dout_valid, 0);
    for (int i = 0; i < 4; i++) send(16);
    send(0);
    chk("fresh_valid", dout_valid, 1);
    chk("fresh_dout", dout, 4);
    idle(4);
    m_cnt = 1;
    decim_n = 8'd1;
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    m_cnt = 0;

    // Full FIFO, push and pop on the same edge: no overflow
    dout_ready = 1'b0;
    for (int k = 7; k <= 10; k++) send(16 * k);
    idle(2);
    chk("full2_head", dout, 7);
    send(16 * 11);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    chk("simul_ovf", ovf, 0);
    chk("simul_head", dout, 8);
    pops = 0;
    dout_ready = 1'b1;
    idle(6);
    chk("simul_pops", pops, 4);
    chk("q_empty_end", exp_q.size(), 0);
`ifdef FIR_DECIM_SAT_CNT_EN
    chk("sat_cnt_end", sat_cnt, m_sat);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
